// File: rtl/yarvi_me_pkg.sv
// yarvi_me_pkg: shared widths, size encodings, MMIO base and load/store lane helpers for the memory stage.
package yarvi_me_pkg;
  localparam int XMSB = 63;
  localparam int VMSB = 63;
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;
  localparam logic [VMSB:0] IO_BASE_DEF = 64'h8000_0000;
  typedef enum logic {INIT, RUN} state_e;
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    return sz == MEM_SIZE_B ? 3'd0 : sz == MEM_SIZE_H ? 3'd1 : sz == MEM_SIZE_W ? 3'd3 : 3'd7;
  endfunction
  function automatic logic [7:0] byte_en(input logic [1:0] sz);
    return sz == MEM_SIZE_B ? 8'h01 : sz == MEM_SIZE_H ? 8'h03 : sz == MEM_SIZE_W ? 8'h0f : 8'hff;
  endfunction
  // Right-justified data masked to the access size, optionally sign-extended.
  function automatic logic [XMSB:0] load_ext(input logic [XMSB:0] d, input logic [1:0] sz, input logic sx);
    return sz == MEM_SIZE_B ? {{56{sx & d[7]}}, d[7:0]} :
           sz == MEM_SIZE_H ? {{48{sx & d[15]}}, d[15:0]} :
           sz == MEM_SIZE_W ? {{32{sx & d[31]}}, d[31:0]} : d;
  endfunction
endpackage

// File: rtl/yarvi_me_if.sv
// yarvi_me_if: execute-to-memory request bus plus the memory stage's response and MMIO outputs.
interface yarvi_me_if;
  import yarvi_me_pkg::*;
  logic            ex_mem_valid;
  logic            ex_mem_writeenable;
  logic [VMSB:0]   ex_mem_address;
  logic [XMSB:0]   ex_mem_writedata;
  logic [1:0]      ex_mem_sizelg2;
  logic [4:0]      ex_mem_readtag;
  logic            ex_mem_readsignextend;
  logic            me_ready;
  logic            me_readdatavalid;
  logic [4:0]      me_readdatatag;
  logic [XMSB:0]   me_readdata;
  logic            me_misaligned;
  logic            me_tohost_valid;
  logic [63:0]     me_tohost;
  modport master (
    output ex_mem_valid, ex_mem_writeenable, ex_mem_address, ex_mem_writedata,
           ex_mem_sizelg2, ex_mem_readtag, ex_mem_readsignextend,
    input  me_ready, me_readdatavalid, me_readdatatag, me_readdata,
           me_misaligned, me_tohost_valid, me_tohost
  );
  modport slave (
    input  ex_mem_valid, ex_mem_writeenable, ex_mem_address, ex_mem_writedata,
           ex_mem_sizelg2, ex_mem_readtag, ex_mem_readsignextend,
    output me_ready, me_readdatavalid, me_readdatatag, me_readdata,
           me_misaligned, me_tohost_valid, me_tohost
  );
endinterface

// File: rtl/yarvi_me_dmem.sv
// yarvi_me_dmem: single-port synchronous 64-bit RAM with byte enables, read-first, left unreset for block RAM inference.
module yarvi_me_dmem #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem_q [2**AW];
  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int i = 0; i < 8; i++)
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/yarvi_me.sv
// yarvi_me: RV64I memory stage; zeroes the data RAM after reset, then serves loads/stores and a tohost/cycle-counter MMIO window.
module yarvi_me import yarvi_me_pkg::*; #(
  parameter int            MEM_WORDS_LG2 = 10,
  parameter logic [VMSB:0] IO_BASE       = IO_BASE_DEF
) (
  input logic       clock,
  input logic       reset_n,
  yarvi_me_if.slave bus
);
  localparam logic [VMSB:0] IO_CNT = IO_BASE + 8;
  state_e                   state_q, state_d;
  logic [MEM_WORDS_LG2-1:0] clr_q, clr_d;
  logic [63:0]              cnt_q;
  logic                     a_valid_q, a_we_q, a_sext_q;
  logic [VMSB:0]            a_addr_q;
  logic [XMSB:0]            a_wdata_q;
  logic [1:0]               a_size_q;
  logic [4:0]               a_tag_q;
  logic                     b_valid_q, b_sext_q, b_io_q;
  logic [2:0]               b_off_q;
  logic [1:0]               b_size_q;
  logic [4:0]               b_tag_q;
  logic [63:0]              b_iodata_q;
  logic                     rdv_q, tohost_valid_q;
  logic [4:0]               rdtag_q;
  logic [XMSB:0]            rdata_q;
  logic [63:0]              tohost_q;
  logic                     init, accept, a_mis, a_io, a_ok, a_tohost, ram_we;
  logic [7:0]               ram_be;
  logic [MEM_WORDS_LG2-1:0] ram_addr;
  logic [63:0]              ram_wdata, ram_rdata, b_word;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  always_comb begin
    state_d = (state_q == INIT && &clr_q) ? RUN : state_q;
    clr_d   = (state_q == INIT) ? clr_q + 1'b1 : clr_q;
  end
  assign init     = state_q == INIT;
  assign accept   = bus.ex_mem_valid && !init;
  assign a_mis    = |(a_addr_q[2:0] & align_mask(a_size_q));
  assign a_io     = a_addr_q >= IO_BASE;
  assign a_ok     = a_valid_q && !a_mis;
  assign a_tohost = a_ok && a_we_q && a_addr_q == IO_BASE;
  // The clearing sweep owns the single RAM port while in INIT.
  assign ram_we    = init || (a_ok && a_we_q && !a_io);
  assign ram_be    = init ? 8'hff : byte_en(a_size_q) << a_addr_q[2:0];
  assign ram_addr  = init ? clr_q : a_addr_q[MEM_WORDS_LG2+2:3];
  assign ram_wdata = init ? '0 : a_wdata_q << {a_addr_q[2:0], 3'b000};
  assign b_word    = b_io_q ? b_iodata_q : ram_rdata;
  yarvi_me_dmem #(.AW(MEM_WORDS_LG2)) u_dmem (
    .clk_i   (clock),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt_q          <= '0;
      a_valid_q      <= 1'b0;
      a_we_q         <= 1'b0;
      a_sext_q       <= 1'b0;
      a_addr_q       <= '0;
      a_wdata_q      <= '0;
      a_size_q       <= '0;
      a_tag_q        <= '0;
      b_valid_q      <= 1'b0;
      b_sext_q       <= 1'b0;
      b_io_q         <= 1'b0;
      b_off_q        <= '0;
      b_size_q       <= '0;
      b_tag_q        <= '0;
      b_iodata_q     <= '0;
      rdv_q          <= 1'b0;
      rdtag_q        <= '0;
      rdata_q        <= '0;
      tohost_valid_q <= 1'b0;
      tohost_q       <= '0;
    end else begin
      cnt_q     <= cnt_q + 64'd1;
      a_valid_q <= accept;
      if (accept) begin
        a_we_q    <= bus.ex_mem_writeenable;
        a_sext_q  <= bus.ex_mem_readsignextend;
        a_addr_q  <= bus.ex_mem_address;
        a_wdata_q <= bus.ex_mem_writedata;
        a_size_q  <= bus.ex_mem_sizelg2;
        a_tag_q   <= bus.ex_mem_readtag;
      end
      b_valid_q  <= a_ok && !a_we_q;
      b_sext_q   <= a_sext_q;
      b_io_q     <= a_io;
      b_off_q    <= a_addr_q[2:0];
      b_size_q   <= a_size_q;
      b_tag_q    <= a_tag_q;
      b_iodata_q <= a_addr_q == IO_CNT ? cnt_q : '0;
      rdv_q      <= b_valid_q;
      if (b_valid_q) begin
        rdtag_q <= b_tag_q;
        rdata_q <= load_ext(b_word >> {b_off_q, 3'b000}, b_size_q, b_sext_q);
      end
      tohost_valid_q <= a_tohost;
      if (a_tohost) tohost_q <= load_ext(a_wdata_q, a_size_q, 1'b0);
    end
  assign bus.me_ready         = state_q == RUN;
  assign bus.me_readdatavalid = rdv_q;
  assign bus.me_readdatatag   = rdtag_q;
  assign bus.me_readdata      = rdata_q;
  assign bus.me_misaligned    = a_valid_q && a_mis;
  assign bus.me_tohost_valid  = tohost_valid_q;
  assign bus.me_tohost        = tohost_q;
endmodule

// File: tb/tb_yarvi_me.sv
// tb_yarvi_me: directed vectors for yarvi_me with a 16-word RAM, checked by immediate assertions.
module tb_yarvi_me;
  import yarvi_me_pkg::*;
  localparam logic [63:0] IOB = 64'h8000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] cyc;
  logic [63:0] v1, v2, e1;
  yarvi_me_if bus();
  yarvi_me #(.MEM_WORDS_LG2(4), .IO_BASE(IOB)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= '0;
    else cyc <= cyc + 64'd1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [1:0] sz, input logic [4:0] tag, input logic sx);
    bus.ex_mem_valid          = 1'b1;
    bus.ex_mem_writeenable    = we;
    bus.ex_mem_address        = addr;
    bus.ex_mem_writedata      = wd;
    bus.ex_mem_sizelg2        = sz;
    bus.ex_mem_readtag        = tag;
    bus.ex_mem_readsignextend = sx;
    step();
    bus.ex_mem_valid = 1'b0;
  endtask
  task automatic do_load(input string tg, input logic [63:0] addr, input logic [1:0] sz,
                         input logic sx, input logic [4:0] tag, input logic [63:0] exp);
    issue(1'b0, addr, 64'h0, sz, tag, sx);
    step();
    chk({tg, "_early"}, bus.me_readdatavalid, 1'b0);
    step();
    chk({tg, "_valid"}, bus.me_readdatavalid, 1'b1);
    chk({tg, "_tag"}, bus.me_readdatatag, tag);
    chk({tg, "_data"}, bus.me_readdata, exp);
  endtask
  initial begin
    bus.ex_mem_valid = 1'b0;
    bus.ex_mem_writeenable = 1'b0;
    bus.ex_mem_address = '0;
    bus.ex_mem_writedata = '0;
    bus.ex_mem_sizelg2 = '0;
    bus.ex_mem_readtag = '0;
    bus.ex_mem_readsignextend = 1'b0;
    step();
    step();
    chk("rst_ready", bus.me_ready, 1'b0);
    chk("rst_rdv", bus.me_readdatavalid, 1'b0);
    chk("rst_tag", bus.me_readdatatag, 5'd0);
    chk("rst_rdata", bus.me_readdata, 64'd0);
    chk("rst_mis", bus.me_misaligned, 1'b0);
    chk("rst_thv", bus.me_tohost_valid, 1'b0);
    chk("rst_tohost", bus.me_tohost, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("init_ready_low", bus.me_ready, 1'b0);
    end
    step();
    chk("init_ready_high", bus.me_ready, 1'b1);
    do_load("zero_ld", 64'h48, MEM_SIZE_D, 1'b0, 5'd3, 64'h0);
    issue(1'b1, 64'h10, 64'h8877665544332211, MEM_SIZE_D, 5'd0, 1'b0);
    do_load("lb_sx", 64'h17, MEM_SIZE_B, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF88);
    do_load("lbu", 64'h17, MEM_SIZE_B, 1'b0, 5'd6, 64'h88);
    do_load("lh_sx", 64'h16, MEM_SIZE_H, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_8877);
    do_load("lwu", 64'h14, MEM_SIZE_W, 1'b0, 5'd8, 64'h8877_6655);
    do_load("lw_sx", 64'h14, MEM_SIZE_W, 1'b1, 5'd9, 64'hFFFF_FFFF_8877_6655);
    do_load("ld_sx_ign", 64'h10, MEM_SIZE_D, 1'b1, 5'd10, 64'h8877665544332211);
    issue(1'b1, 64'h24, 64'hDEADBEEF, MEM_SIZE_W, 5'd0, 1'b0);
    do_load("sw_ld", 64'h20, MEM_SIZE_D, 1'b0, 5'd11, 64'hDEADBEEF_0000_0000);
    issue(1'b0, 64'h3, 64'h0, MEM_SIZE_H, 5'd12, 1'b1);
    chk("lh_mis_pulse", bus.me_misaligned, 1'b1);
    step();
    chk("lh_mis_gone", bus.me_misaligned, 1'b0);
    step();
    chk("lh_mis_nordv", bus.me_readdatavalid, 1'b0);
    step();
    chk("lh_mis_nordv2", bus.me_readdatavalid, 1'b0);
    issue(1'b1, 64'h5, 64'hFFFF, MEM_SIZE_H, 5'd0, 1'b0);
    chk("sh_mis_pulse", bus.me_misaligned, 1'b1);
    do_load("mis_unchanged", 64'h0, MEM_SIZE_D, 1'b0, 5'd13, 64'h0);
    issue(1'b1, IOB, 64'h1, MEM_SIZE_W, 5'd0, 1'b0);
    chk("th_early", bus.me_tohost_valid, 1'b0);
    step();
    chk("th_pulse", bus.me_tohost_valid, 1'b1);
    chk("th_value", bus.me_tohost, 64'h1);
    step();
    chk("th_pulse_end", bus.me_tohost_valid, 1'b0);
    issue(1'b1, IOB + 64'd16, 64'h7, MEM_SIZE_D, 5'd0, 1'b0);
    step();
    chk("th_other_nopulse", bus.me_tohost_valid, 1'b0);
    chk("th_other_hold", bus.me_tohost, 64'h1);
    issue(1'b1, IOB, 64'h1F0, MEM_SIZE_B, 5'd0, 1'b0);
    step();
    chk("th_sb_pulse", bus.me_tohost_valid, 1'b1);
    chk("th_sb_zext", bus.me_tohost, 64'hF0);
    issue(1'b0, IOB + 64'd8, 64'h0, MEM_SIZE_D, 5'd14, 1'b0);
    e1 = cyc;
    step();
    step();
    chk("cnt1_valid", bus.me_readdatavalid, 1'b1);
    chk("cnt1_value", bus.me_readdata, e1);
    v1 = bus.me_readdata;
    issue(1'b0, IOB + 64'd8, 64'h0, MEM_SIZE_D, 5'd15, 1'b0);
    step();
    step();
    chk("cnt2_valid", bus.me_readdatavalid, 1'b1);
    v2 = bus.me_readdata;
    chk("cnt_delta", v2 - v1, 64'd3);
    do_load("io_other_ld", IOB + 64'd16, MEM_SIZE_D, 1'b0, 5'd16, 64'h0);
    do_load("io_off_lw", IOB + 64'd12, MEM_SIZE_W, 1'b1, 5'd17, 64'h0);
    issue(1'b0, 64'h10, 64'h0, MEM_SIZE_D, 5'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.me_ready, 1'b0);
    chk("mid_rst_rdata", bus.me_readdata, 64'h0);
    chk("mid_rst_tag", bus.me_readdatatag, 5'd0);
    chk("mid_rst_tohost", bus.me_tohost, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_nordv", bus.me_readdatavalid, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("reinit_ready_low", bus.me_ready, 1'b0);
      chk("reinit_nordv", bus.me_readdatavalid, 1'b0);
    end
    step();
    chk("reinit_ready_high", bus.me_ready, 1'b1);
    chk("reinit_nordv_end", bus.me_readdatavalid, 1'b0);
    do_load("reinit_cleared", 64'h10, MEM_SIZE_D, 1'b0, 5'd18, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
